// File: rtl/ldpc_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ldpc_mem_pkg
// Description : Shared types and helpers for the LDPC decoder memory
//               subsystem.
//               - arb_state_t   : ext_ram_arbiter FSM state encoding
//               - onehot_to_idx : converts a one-hot vector (up to MAX_REQ
//                                 bits) to a binary index
//               - RD_LATENCY    : read-return latency of the arbiter, in cycles
// Revision    : 1.0 - initial release
// ============================================================================
package ldpc_mem_pkg;

  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Cycles from a read grant to the rd_valid/rd_data return
  localparam int RD_LATENCY = 1;

  // Largest supported requester count and the matching index width
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  // A zero vector maps to index 0. Callers check validity separately.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational round-robin picker. It grants the first
//               asserted request found by searching upward from ptr_i and
//               wrapping modulo NUM_REQ.
// Ports       : req_i   - request vector
//               ptr_i   - search start index (0..NUM_REQ-1)
//               gnt_o   - one-hot grant (zero when no request)
//               idx_o   - binary index of the granted requester
//               valid_o - at least one request was granted
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
  import ldpc_mem_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               valid_o
);

  int                 cand_int;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] cand_mask;

  always_comb begin
    gnt_o     = '0;
    valid_o   = 1'b0;
    cand_int  = 0;
    cand      = '0;
    cand_mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_int  = (int'(ptr_i) + k) % NUM_REQ;
      cand      = cand_int[IDX_W-1:0];
      cand_mask = NUM_REQ'(1) << cand;
      if (!valid_o && |(req_i & cand_mask)) begin
        gnt_o   = cand_mask;
        valid_o = 1'b1;
      end
    end
    idx_o = onehot_to_idx(MAX_REQ'(gnt_o));
  end

endmodule
`default_nettype wire

// File: rtl/ext_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ext_ram_arbiter
// Description : Shares the single-port EXT_RAM (synchronous write,
//               combinational read) between NUM_REQ requesters. It grants
//               one access per cycle in round-robin order and returns
//               registered read data with a one-hot rd_valid one cycle after
//               the grant.
// Config      : `EXT_RAM_ARB_LOCK_EN - when defined, a requester that holds
//               req_lock keeps ownership (LOCKED state) for up to MAX_LOCK
//               consecutive grants. When undefined, req_lock is ignored.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               req_i/req_we_i    - per-requester request / write select
//               req_lock_i        - keep ownership after this grant
//               req_addr_i        - packed addresses, slice i = requester i
//               req_wdata_i       - packed write data
//               gnt_o             - combinational one-hot grant
//               rd_valid_o        - one-hot read return marker
//               rd_data_o         - registered read data (broadcast)
//               ram_*_o           - drive to EXT_RAM ports
//               ram_data_out_i    - EXT_RAM data_out
// Revision    : 1.0 - initial release
// ============================================================================
module ext_ram_arbiter
  import ldpc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REQ    = 3,
  parameter int MAX_LOCK   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ-1:0]            req_lock_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rd_valid_o,
  output logic [DATA_WIDTH-1:0]         rd_data_o,
  output logic [ADDR_WIDTH-1:0]         ram_address_o,
  output logic [DATA_WIDTH-1:0]         ram_data_in_o,
  output logic                          ram_write_en_o,
  output logic                          ram_chip_sel_o,
  input  logic [DATA_WIDTH-1:0]         ram_data_out_i
);

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0]    rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  logic [NUM_REQ-1:0]    pick_gnt;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_valid;
  logic [NUM_REQ-1:0]    gnt;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

`ifdef EXT_RAM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0] owner_mask;
  logic               owner_req;
  logic               owner_lock;
  logic               pick_lock;
  logic               arb_mode;

  assign owner_mask = NUM_REQ'(1) << owner_q;
  assign owner_req  = |(req_i & owner_mask);
  assign owner_lock = |(req_lock_i & owner_mask);
  assign pick_lock  = |(req_lock_i & pick_gnt);

  always_comb begin
    gnt        = '0;
    rr_ptr_d   = rr_ptr_q;
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    // An owner that has dropped both req and req_lock gives up the RAM in
    // the same cycle, so the others can be arbitrated without a bubble.
    arb_mode   = (state_q == ARB) || (!owner_req && !owner_lock);

    if (arb_mode) begin
      state_d    = ARB;
      lock_cnt_d = '0;
      gnt        = pick_gnt;
      if (pick_valid) begin
        rr_ptr_d = next_idx(pick_idx);
        // With MAX_LOCK <= 1 the first grant already exhausts the budget.
        if (pick_lock && (MAX_LOCK > 1)) begin
          state_d    = LOCKED;
          owner_d    = pick_idx;
          lock_cnt_d = CNT_W'(1);
        end
      end
    end else begin
      // Owner holds the lock: only it may be granted, others wait.
      rr_ptr_d = next_idx(owner_q);
      if (owner_req) begin
        gnt        = owner_mask;
        lock_cnt_d = lock_cnt_q + CNT_W'(1);
        if (!owner_lock || (lock_cnt_q + CNT_W'(1) == CNT_W'(MAX_LOCK))) begin
          state_d    = ARB;
          lock_cnt_d = '0;
        end
      end
    end

    if (rst) begin
      gnt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB;
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  // Lock requests have no effect in this build.
  logic unused_lock;
  assign unused_lock = ^req_lock_i;

  always_comb begin
    gnt      = pick_gnt;
    rr_ptr_d = rr_ptr_q;
    if (pick_valid) begin
      rr_ptr_d = next_idx(pick_idx);
    end
    if (rst) begin
      gnt = '0;
    end
  end
`endif

  // RAM drive: AND-OR mux of the granted requester; all zero with no grant.
  always_comb begin
    ram_address_o  = '0;
    ram_data_in_o  = '0;
    ram_chip_sel_o = |gnt;
    ram_write_en_o = |(gnt & req_we_i);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        ram_address_o = ram_address_o | req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram_data_in_o = ram_data_in_o | req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign rd_valid_d = gnt & ~req_we_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rd_valid_q <= rd_valid_d;
      // Hold the last returned word between reads.
      if (|rd_valid_d) begin
        rd_data_q <= ram_data_out_i;
      end
    end
  end

  assign gnt_o      = gnt;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_ext_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ext_ram_arbiter
// Description : Directed self-checking bench for ext_ram_arbiter with a
//               behavioural EXT_RAM (synchronous write, combinational read).
//               Lock scenarios follow `EXT_RAM_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ext_ram_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 3;

  logic           clk;
  logic           rst;
  logic [NR-1:0]  req, req_we, req_lock;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]  gnt, rd_valid;
  logic [DW-1:0]  rd_data;
  logic [AW-1:0]  ram_address;
  logic [DW-1:0]  ram_data_in, ram_data_out;
  logic           ram_write_en, ram_chip_sel;

  logic [DW-1:0]  mem [0:255];

  int n_cmp;
  int n_err;

  ext_ram_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .NUM_REQ    (NR),
    .MAX_LOCK   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_i          (req),
    .req_we_i       (req_we),
    .req_lock_i     (req_lock),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .gnt_o          (gnt),
    .rd_valid_o     (rd_valid),
    .rd_data_o      (rd_data),
    .ram_address_o  (ram_address),
    .ram_data_in_o  (ram_data_in),
    .ram_write_en_o (ram_write_en),
    .ram_chip_sel_o (ram_chip_sel),
    .ram_data_out_i (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EXT_RAM model
  always @(posedge clk) begin
    if (ram_chip_sel && ram_write_en) begin
      mem[ram_address] <= ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int i, input logic r, input logic w, input logic l,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[i]              = r;
    req_we[i]           = w;
    req_lock[i]         = l;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_reqs();
    req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int a = 0; a < 256; a++) mem[a] = '0;
    rst = 1'b1;
    clear_reqs();

    // ---- reset: outputs forced low even with requests pending
    tick();
    req = 3'b111;
    settle();
    check("gnt_during_rst", 32'(gnt), 32'h0);
    check("cs_during_rst", 32'(ram_chip_sel), 32'h0);
    tick();
    rst = 1'b0;
    clear_reqs();
    settle();
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_ram_drive", {ram_chip_sel, ram_write_en, ram_address, ram_data_in}, 32'h0);

    // ---- single write then read, requester 0
    drive(0, 1, 1, 0, 8'd0, 8'd75);
    settle();
    check("wr_gnt", 32'(gnt), 32'b001);
    check("wr_ram", {ram_chip_sel, ram_write_en, ram_address, ram_data_in}, {2'b11, 8'd0, 8'd75});
    tick();
    drive(0, 1, 0, 0, 8'd0, 8'd0);
    settle();
    check("rd_gnt", 32'(gnt), 32'b001);
    check("rd_we", 32'(ram_write_en), 32'h0);
    check("no_rdv_after_wr", 32'(rd_valid), 32'h0);
    tick();
    clear_reqs();
    settle();
    check("rd0_valid", 32'(rd_valid), 32'b001);
    check("rd0_data", 32'(rd_data), 32'd75);

    // ---- three simultaneous reads after reset
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem[10] = 8'hA0;
    mem[11] = 8'hA1;
    mem[12] = 8'hA2;
    drive(0, 1, 0, 0, 8'd10, 8'd0);
    drive(1, 1, 0, 0, 8'd11, 8'd0);
    drive(2, 1, 0, 0, 8'd12, 8'd0);
    settle();
    check("rr_gnt0", 32'(gnt), 32'b001);
    check("rr_addr0", 32'(ram_address), 32'd10);
    tick();
    drive(0, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check("rr_gnt1", 32'(gnt), 32'b010);
    check("rr_addr1", 32'(ram_address), 32'd11);
    check("rr_rdv0", 32'(rd_valid), 32'b001);
    check("rr_rdd0", 32'(rd_data), 32'hA0);
    tick();
    drive(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check("rr_gnt2", 32'(gnt), 32'b100);
    check("rr_rdv1", 32'(rd_valid), 32'b010);
    check("rr_rdd1", 32'(rd_data), 32'hA1);
    tick();
    drive(2, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check("rr_idle_gnt", 32'(gnt), 32'h0);
    check("rr_rdv2", 32'(rd_valid), 32'b100);
    check("rr_rdd2", 32'(rd_data), 32'hA2);
    tick();
    settle();
    check("rr_rdv_end", 32'(rd_valid), 32'h0);

    // ---- read after write, same address (rr_ptr is back at 0)
    drive(1, 1, 1, 0, 8'd1, 8'd13);
    settle();
    check("raw_wr_gnt", 32'(gnt), 32'b010);
    tick();
    drive(1, 0, 0, 0, 8'd0, 8'd0);
    drive(2, 1, 0, 0, 8'd1, 8'd0);
    settle();
    check("raw_rd_gnt", 32'(gnt), 32'b100);
    tick();
    drive(2, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check("raw_rdv", 32'(rd_valid), 32'b100);
    check("raw_rdd", 32'(rd_data), 32'd13);

`ifdef EXT_RAM_ARB_LOCK_EN
    // ---- lock: req0 holds 4 accesses, req1 waits, then req1 in cycle 5
    drive(0, 1, 0, 1, 8'd0, 8'd0);
    drive(1, 1, 0, 0, 8'd1, 8'd0);
    settle();
    check("lock_gnt_c1", 32'(gnt), 32'b001);
    for (int k = 2; k <= 4; k++) begin
      tick();
      settle();
      check($sformatf("lock_gnt_c%0d", k), 32'(gnt), 32'b001);
    end
    tick();
    drive(0, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check("lock_gnt_c5", 32'(gnt), 32'b010);
    tick();
    drive(1, 0, 0, 0, 8'd0, 8'd0);
    settle();
    check("lock_rdv", 32'(rd_valid), 32'b010);
    check("lock_rdd", 32'(rd_data), 32'd13);

    // ---- forced release after 16 locked grants (rr_ptr = 2, req2 idle)
    drive(0, 1, 0, 1, 8'd0, 8'd0);
    drive(1, 1, 0, 0, 8'd1, 8'd0);
    settle();
    check("force_gnt_1", 32'(gnt), 32'b001);
    for (int k = 2; k <= 16; k++) begin
      tick();
      settle();
      check($sformatf("force_gnt_%0d", k), 32'(gnt), 32'b001);
    end
    tick();
    settle();
    check("force_release_gnt", 32'(gnt), 32'b010);
`else
    // ---- lock disabled: req_lock ignored, grants alternate 0,1,0,1
    drive(0, 1, 0, 1, 8'd0, 8'd0);
    drive(1, 1, 0, 0, 8'd1, 8'd0);
    settle();
    check("alt_gnt_0", 32'(gnt), 32'b001);
    tick();
    settle();
    check("alt_gnt_1", 32'(gnt), 32'b010);
    tick();
    settle();
    check("alt_gnt_2", 32'(gnt), 32'b001);
    tick();
    settle();
    check("alt_gnt_3", 32'(gnt), 32'b010);
`endif
    tick();
    clear_reqs();
    settle();
    check("req1_rdv", 32'(rd_valid), 32'b010);
    check("req1_rdd", 32'(rd_data), 32'd13);

    // ---- reset in a read grant cycle (rr_ptr = 2 beforehand)
    tick();
    rst = 1'b1;
    drive(2, 1, 0, 0, 8'd0, 8'd0);
    settle();
    check("rstg_gnt", 32'(gnt), 32'h0);
    check("rstg_cs", 32'(ram_chip_sel), 32'h0);
    tick();
    rst = 1'b0;
    clear_reqs();
    settle();
    check("rstg_rdv", 32'(rd_valid), 32'h0);
    check("rstg_rdd", 32'(rd_data), 32'h0);
    check("rstg_ram", {ram_chip_sel, ram_write_en, ram_address, ram_data_in}, 32'h0);
    tick();
    drive(1, 1, 0, 0, 8'd0, 8'd0);
    drive(2, 1, 0, 0, 8'd0, 8'd0);
    settle();
    check("rstg_first_gnt", 32'(gnt), 32'b010);
    tick();
    clear_reqs();
    settle();
    check("rstg_after_rdv", 32'(rd_valid), 32'b010);
    check("rstg_after_rdd", 32'(rd_data), 32'd75);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
